traffic_light_scheduler: RTL
============================

// Module: traffic_light_scheduler
// PURPOSE
//  Sequences a two-road intersection (A, B) on top of the seconds-countdown timer datapath.
//  Each road steps through GREEN -> YELLOW -> ALL-RED. Green durations come from the set-mode configuration.
//  A pedestrian request shortens the current green.
//  Drives the per-road lamp codes, the remaining-seconds digit for the 7-segment path, and a request-pending LED.
// PARAMETERS
//  TICK_CYCLES  25000000  clk cycles per second tick (25 MHz board; bench overrides to 4)
//  YELLOW_SEC   2         yellow duration, seconds (1..9)
//  ALLRED_SEC   1         all-red clearance duration, seconds (1..9)
//  PED_CUT      3         remaining green after a pedestrian truncation, seconds (1..9)
// PORTS
//  clk       in   1  system clock; the only clock
//  rst       in   1  synchronous reset, active-high
//  set       in   1  1 = configuration mode (all red, hold); 0 = run
//  green_a   in   4  road A green duration, seconds (binary)
//  green_b   in   4  road B green duration, seconds (binary)
//  ped_req   in   1  pedestrian request, level or pulse, sampled every cycle
//  light_a   out  2  road A lamp: 2'b00 green, 2'b01 yellow, 2'b10 red
//  light_b   out  2  road B lamp, same encoding
//  cur_sec   out  4  remaining seconds in current state (0 in CFG)
//  phase     out  3  state id (encoding below)
//  led       out  1  pedestrian request pending
// BEHAVIOUR
//  Reset (rst=1 at a clk edge) gives:
//  - phase=ALLRED_B, cur_sec=ALLRED_SEC, light_a=light_b=2'b10
//  - prescaler=0, led=0
//  Reset wins over every other input, including mid-state.
//  States (phase encoding):
//  - 0 CFG
//  - 1 A_GRN
//  - 2 A_YEL
//  - 3 ALLRED_A (after A)
//  - 4 B_GRN
//  - 5 B_YEL
//  - 6 ALLRED_B (after B)
//  Lamps per state:
//  - A_GRN: A=00, B=10
//  - A_YEL: A=01, B=10
//  - B_GRN: A=10, B=00
//  - B_YEL: A=10, B=01
//  - CFG and both ALLRED states: A=10, B=10
//  Prescaler:
//  - Counts 0..TICK_CYCLES-1 and wraps; tick=1 in the cycle where prescaler==TICK_CYCLES-1.
//  - Held at 0 while in CFG.
//  Countdown and state changes:
//  - On tick with cur_sec>1: cur_sec decrements by 1.
//  - On tick with cur_sec==1: advance state and load the new state's duration; visible the next cycle.
//  - Order: ALLRED_B->A_GRN->A_YEL->ALLRED_A->B_GRN->B_YEL->ALLRED_B.
//  - Prescaler is not cleared on state change; transitions stay tick-aligned.
//  Green load value:
//  - green_x==0 loads 1.
//  - green_x>9 loads 9 (single BCD digit).
//  - Otherwise loads green_x, sampled at load time.
//  Set mode:
//  - set=1 in any state: next cycle phase=CFG, cur_sec=0, prescaler=0, led=0.
//  - Leaving CFG (set=0) enters ALLRED_B with cur_sec=ALLRED_SEC on the next cycle.
//  Pedestrian request:
//  - ped_req=1 outside CFG sets led=1 next cycle; ignored in CFG.
//  - While led=1 in A_GRN/B_GRN with cur_sec>PED_CUT: next cycle cur_sec=PED_CUT (truncation beats a same-cycle decrement).
//  - If cur_sec<=PED_CUT, no change.
//  - led clears on entry to A_YEL or B_YEL; a ped_req in that same cycle re-arms it.
//  - A request made during yellow or all-red truncates the next green.
//  Widths:
//  - cur_sec is 4-bit and never exceeds 9 and never underflows.
//  - prescaler is $clog2(TICK_CYCLES) bits.
// TESTING  (TICK_CYCLES=4, YELLOW_SEC=2, ALLRED_SEC=1, PED_CUT=3)
//  1. Reset release: rst high 2 cycles, then low -> ALLRED_B, lamps 10/10, cur_sec=1; 4 cycles later phase=1, light_a=00, cur_sec=green_a.
//  2. Full cycle, green_a=3, green_b=2 -> A_GRN 12, A_YEL 8, ALLRED_A 4, B_GRN 8, B_YEL 8, ALLRED_B 4 cycles; period 44 cycles; cur_sec 3,2,1 in A_GRN.
//  3. Pedestrian, green_a=9, ped_req pulse at A_GRN cur_sec=9 -> led=1 next cycle, cur_sec=3 the cycle after; led=0 on A_YEL entry.
//  4. set=1 mid B_YEL -> next cycle phase=0, lamps 10/10, cur_sec=0, led=0; set=0 -> phase=6, cur_sec=1 next cycle.
//  5. Clamping: green_a=0 -> A_GRN lasts 4 cycles (cur_sec=1); green_b=4'hC -> B_GRN loads cur_sec=9, lasts 36 cycles.
//  6. rst mid A_YEL with led=1 -> next cycle full reset values (phase=6, cur_sec=1, led=0, lamps 10/10).

Source files
------------

// File: rtl/traffic_light_scheduler.sv
// Two-road intersection sequencer: green/yellow/all-red per road on a seconds countdown,
// with pedestrian green truncation and a configuration hold mode.
module traffic_light_scheduler #(
  parameter int unsigned TICK_CYCLES = 25000000,
  parameter int unsigned YELLOW_SEC  = 2,
  parameter int unsigned ALLRED_SEC  = 1,
  parameter int unsigned PED_CUT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [3:0] green_a,
  input  logic [3:0] green_b,
  input  logic       ped_req,
  output logic [1:0] light_a,
  output logic [1:0] light_b,
  output logic [3:0] cur_sec,
  output logic [2:0] phase,
  output logic       led
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [1:0] LAMP_GRN = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_RED = 2'b10;

  typedef enum logic [2:0] {
    CFG      = 3'd0,
    A_GRN    = 3'd1,
    A_YEL    = 3'd2,
    ALLRED_A = 3'd3,
    B_GRN    = 3'd4,
    B_YEL    = 3'd5,
    ALLRED_B = 3'd6
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [3:0]    load_sec;
  logic          is_green;

  // Green duration must fit a single display digit and never be zero.
  function automatic logic [3:0] green_load(input logic [3:0] g);
    logic [3:0] r;
    r = g;
    if (g == 4'd0) r = 4'd1;
    else if (g > 4'd9) r = 4'd9;
    return r;
  endfunction

  function automatic logic [1:0] lamp_a(input state_t s);
    logic [1:0] r;
    r = LAMP_RED;
    if (s == A_GRN) r = LAMP_GRN;
    else if (s == A_YEL) r = LAMP_YEL;
    return r;
  endfunction

  function automatic logic [1:0] lamp_b(input state_t s);
    logic [1:0] r;
    r = LAMP_RED;
    if (s == B_GRN) r = LAMP_GRN;
    else if (s == B_YEL) r = LAMP_YEL;
    return r;
  endfunction

  // Successor state and its duration, used only when the countdown expires.
  always_comb begin
    next_state = state;
    load_sec   = 4'd0;
    tick       = (prescaler == PW'(TICK_CYCLES - 1));
    is_green   = (state == A_GRN) || (state == B_GRN);
    unique case (state)
      ALLRED_B: begin next_state = A_GRN;    load_sec = green_load(green_a); end
      A_GRN:    begin next_state = A_YEL;    load_sec = 4'(YELLOW_SEC);      end
      A_YEL:    begin next_state = ALLRED_A; load_sec = 4'(ALLRED_SEC);      end
      ALLRED_A: begin next_state = B_GRN;    load_sec = green_load(green_b); end
      B_GRN:    begin next_state = B_YEL;    load_sec = 4'(YELLOW_SEC);      end
      B_YEL:    begin next_state = ALLRED_B; load_sec = 4'(ALLRED_SEC);      end
      default:  begin next_state = ALLRED_B; load_sec = 4'(ALLRED_SEC);      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALLRED_B;
      cur_sec   <= 4'(ALLRED_SEC);
      prescaler <= '0;
      led       <= 1'b0;
      light_a   <= LAMP_RED;
      light_b   <= LAMP_RED;
    end else if (set) begin
      state     <= CFG;
      cur_sec   <= 4'd0;
      prescaler <= '0;
      led       <= 1'b0;
      light_a   <= LAMP_RED;
      light_b   <= LAMP_RED;
    end else if (state == CFG) begin
      state     <= ALLRED_B;
      cur_sec   <= 4'(ALLRED_SEC);
      prescaler <= '0;
      led       <= 1'b0;
      light_a   <= LAMP_RED;
      light_b   <= LAMP_RED;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      led       <= led | ped_req;
      // A pending request cuts the green short; this wins over a same-cycle decrement.
      if (led && is_green && (cur_sec > 4'(PED_CUT))) begin
        cur_sec <= 4'(PED_CUT);
      end else if (tick) begin
        if (cur_sec > 4'd1) begin
          cur_sec <= cur_sec - 4'd1;
        end else begin
          state   <= next_state;
          cur_sec <= load_sec;
          light_a <= lamp_a(next_state);
          light_b <= lamp_b(next_state);
          if ((next_state == A_YEL) || (next_state == B_YEL)) led <= ped_req;
        end
      end
    end
  end

  assign phase = state;

endmodule
